icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache.
- Sits directly downstream of the pipelined datapath's fetch port. It consumes imemREN/imemaddr and returns ihit/imemload.
- On a miss it fetches the word from the memory controller over a request/wait handshake.
- Instruction side is read-only; there is no write path and no dirty state.

Parameters:
- NSETS, 16, number of frames; power of two, ≥2. Index width IW = log2(NSETS).
- TAGW, 30-IW, tag width: address bits [31:2+IW].

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- imemREN  input  1  datapath requests instruction at imemaddr
- imemaddr  input  32  byte address of the instruction; bits [1:0] ignored
- ihit  output  1  imemload valid this cycle for the current imemaddr
- imemload  output  32  instruction word
- iREN  output  1  read request to the memory controller
- iaddr  output  32  word-aligned memory address: {latched[31:2],2'b00}
- iwait  input  1  memory busy; fill data is valid when iREN=1 and iwait=0
- iload  input  32  fill data from memory
- hit_count  output  32  number of cycles with ihit=1 (saturating)
- miss_count  output  32  number of misses started (saturating)

Behaviour:
- Address split: idx = imemaddr[2+IW-1:2], tag = imemaddr[31:2+IW].
- Storage per frame: valid (1), tag (TAGW), data (32).
- Reset (async, nRST=0):
  - all valid bits cleared; state=IDLE; hit_count=0; miss_count=0.
  - Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
  - Tag and data arrays need not be reset.
- State IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==tag). ihit=hit combinationally, zero-wait: same cycle as the address.
  - imemload = data[idx] when hit, else 0.
  - imemREN=1 and miss: latch imemaddr into miss_addr, increment miss_count, go to FETCH on the next edge.
  - imemREN=0: no action; ihit=0.
- State FETCH:
  - iREN=1, iaddr={miss_addr[31:2],2'b00}, ihit=0 regardless of imemaddr.
  - iwait=1: stay in FETCH.
  - iwait=0: on this edge write iload into frame miss_addr.idx, set its tag, set valid=1, go to IDLE.
  - The next cycle re-evaluates imemaddr; if it is unchanged, it hits.
  - No same-cycle forwarding of iload to imemload. Miss penalty is memory latency + 1 cycle.
- imemaddr changing during FETCH (branch/jump redirect, stall release):
  - The fill of the latched miss_addr always completes and is never aborted.
  - The new address is evaluated in IDLE after the fill.
- Conflict: a fill overwrites whatever valid frame occupies the index, with no eviction action.
- Outputs outside FETCH: iREN=0, iaddr=0.
- Counters:
  - hit_count increments on each clock edge where ihit=1, including repeated hits while the pipeline is stalled on the same address.
  - Both counters saturate at 32'hFFFF_FFFF.
- Reset asserted mid-FETCH: return to IDLE immediately, drop iREN, invalidate all frames; the partial fill is discarded.
- iaddr/iREN are registered-state derived only: no combinational path from imemaddr to iREN.

Test Plan:
- Cold miss:
  - Stimulus: reset; imemREN=1, imemaddr=0x0000_0040; memory holds 0x2001_0005 with iwait high for 3 cycles.
  - Required: ihit=0; iREN=1 with iaddr=0x40 for 4 cycles; then next cycle ihit=1, imemload=0x2001_0005; miss_count=1.
- Hit after fill:
  - Stimulus: after the cold miss, hold imemaddr=0x40 for 5 cycles.
  - Required: ihit=1 every cycle; hit_count=5; iREN stays 0.
- Conflict:
  - Stimulus: fill 0x0000_0004 (data A); then request 0x0000_0044 (same idx 1, NSETS=16) with data B; then re-request 0x04.
  - Required: 0x44 misses and fills B; 0x04 misses again and returns A; miss_count=3.
- Redirect during FETCH:
  - Stimulus: miss on 0x80; after 1 cycle change imemaddr to 0x100 while iwait=1.
  - Required: iaddr stays 0x80 until iwait=0; frame for 0x80 becomes valid; then a new FETCH starts with iaddr=0x100.
- Byte-offset and REN gating:
  - Stimulus: after filling 0x40, request 0x43.
  - Required: ihit=1, same data as 0x40.
  - Stimulus: imemREN=0 at 0x40.
  - Required: ihit=0, no miss, counters unchanged.
- Async reset mid-fill:
  - Stimulus: assert nRST=0 during FETCH between clock edges.
  - Required: iREN falls without a clock edge; after release, a request to the previously filled 0x40 misses (valid cleared); counters=0.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache for the datapath fetch port.
// Misses are filled from the memory controller over an iREN/iwait handshake.
module icache_direct #(
    parameter int unsigned NSETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int unsigned IW   = $clog2(NSETS);
    localparam int unsigned TAGW = 30 - IW;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t state, next_state;

    logic [NSETS-1:0] valid;
    logic [TAGW-1:0]  tag_mem  [NSETS];
    logic [31:0]      data_mem [NSETS];

    logic [31:2]      miss_addr;
    logic [IW-1:0]    idx;
    logic [TAGW-1:0]  tag;
    logic [IW-1:0]    fill_idx;
    logic [TAGW-1:0]  fill_tag;
    logic             hit;
    logic             miss_start;
    logic             fill_done;
    logic             unused_byte_offset;

    assign idx                = imemaddr[2+IW-1:2];
    assign tag                = imemaddr[31:2+IW];
    assign fill_idx           = miss_addr[2+IW-1:2];
    assign fill_tag           = miss_addr[31:2+IW];
    assign unused_byte_offset = ^imemaddr[1:0];

    assign hit        = (state == IDLE) && imemREN && valid[idx] && (tag_mem[idx] == tag);
    assign miss_start = (state == IDLE) && imemREN && !hit;
    assign fill_done  = (state == FETCH) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? data_mem[idx] : '0;
    // Memory-side outputs depend only on registered state, never on imemaddr.
    assign iREN     = (state == FETCH);
    assign iaddr    = (state == FETCH) ? {miss_addr, 2'b00} : '0;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss_start) next_state = FETCH;
            FETCH:   if (!iwait) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= next_state;
            if (miss_start) begin
                miss_addr <= imemaddr[31:2];
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
            if (hit && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (fill_done) valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

endmodule
